i2s_rx: RTL and testbench

- I2S receiver (deserializer) for an external audio source (MEMS mic, ADC) that shares the SCK/WS pair produced by the team's I2S clock generator.
- Oversamples sck_i/ws_i/sd_i in the clk_i domain and shifts bits in MSB-first with standard I2S one-SCK delay.
- Emits one left/right sample pair per frame through a valid/ready holding register.
- Sits between the I2S pads and the audio DSP/FIFO path.

---
 rtl/i2s_pkg.sv | 8 +
 rtl/i2s_in_sync.sv | 39 +++
 rtl/i2s_rx.sv | 155 +++++++++++++++
 tb/tb_i2s_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S receive path.
package i2s_pkg;
  localparam int I2S_SAMPLE_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH   = 32;

  typedef enum logic {CH_LEFT, CH_RIGHT} ch_e;
  typedef enum logic {RX_SYNC, RX_RECV} rx_state_e;
endpackage

// File: rtl/i2s_in_sync.sv
// Synchronizes sck/ws/sd into clk_i and flags the cycle after SCK rises.
module i2s_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic ws_s_o,
  output logic sd_s_o,
  output logic sck_rise_o
);
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $fatal(1, "i2s_in_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sck_q, ws_q, sd_q;
  logic                   sck_prev_q;

  // All three pins see the same depth so ws/sd line up with the SCK edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q      <= '0;
      ws_q       <= '0;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      ws_q       <= {ws_q[SYNC_STAGES-2:0], ws_i};
      sd_q       <= {sd_q[SYNC_STAGES-2:0], sd_i};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
    end
  end

  assign ws_s_o     = ws_q[SYNC_STAGES-1];
  assign sd_s_o     = sd_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_q[SYNC_STAGES-1] && !sck_prev_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S deserializer: MSB-first words with one-SCK WS delay, emitted as L/R pairs
// through a valid/ready holding register.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int   SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int   SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter logic WS_POL       = 1'b0,
  parameter int   SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sck_i,
  input  logic                    ws_i,
  input  logic                    sd_i,
  output logic [SAMPLE_WIDTH-1:0] left_o,
  output logic [SAMPLE_WIDTH-1:0] right_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o
);
  // Handshake: a pair transfers on a clk_i edge where valid_o && ready_i; data is
  // stable while valid_o is high, and ready_i has no effect while valid_o is low.
  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > SLOT_WIDTH) begin : g_bad_width
    $fatal(1, "i2s_rx: SAMPLE_WIDTH must be 1..SLOT_WIDTH");
  end

  localparam int            CW         = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] SLOT_CNT   = CW'(SLOT_WIDTH);

  logic ws_s, sd_s, sck_rise;

  i2s_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (sck_i),
    .ws_i       (ws_i),
    .sd_i       (sd_i),
    .ws_s_o     (ws_s),
    .sd_s_o     (sd_s),
    .sck_rise_o (sck_rise)
  );

  rx_state_e               state_q, state_d;
  ch_e                     ch_q, ch_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d, shreg_upd, bit_mask;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_vld_q, left_vld_d;
  logic                    ws_prev_q, ws_prev_d;
  logic                    primed_q, primed_d;
  logic                    pair_done;
  logic [SAMPLE_WIDTH-1:0] left_q, right_q;
  logic                    valid_q, overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_SYNC;
      ch_q        <= CH_LEFT;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_vld_q  <= 1'b0;
      ws_prev_q   <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_vld_q  <= left_vld_d;
      ws_prev_q   <= ws_prev_d;
      primed_q    <= primed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_vld_d  = left_vld_q;
    ws_prev_d   = ws_prev_q;
    primed_d    = primed_q;
    pair_done   = 1'b0;
    bit_mask    = '0;
    bit_mask[SAMPLE_WIDTH-1] = sd_s;
    shreg_upd   = shreg_q;
    if (bit_cnt_q < SAMPLE_CNT) shreg_upd = shreg_q | (bit_mask >> bit_cnt_q);

    if (sck_rise) begin
      ws_prev_d = ws_s;
      primed_d  = 1'b1;
      case (state_q)
        // The first rise after reset only learns the WS level, so entry
        // requires a WS transition actually seen on the wire.
        RX_SYNC: begin
          if (primed_q && (ws_s != ws_prev_q)) begin
            state_d   = RX_RECV;
            ch_d      = (ws_s == WS_POL) ? CH_LEFT : CH_RIGHT;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
        RX_RECV: begin
          shreg_d = shreg_upd;
          if (bit_cnt_q < SLOT_CNT) bit_cnt_d = bit_cnt_q + 1'b1;
          if (ws_s != ws_prev_q) begin
            if (ch_q == CH_LEFT) begin
              left_hold_d = shreg_upd;
              left_vld_d  = 1'b1;
            end else if (left_vld_q) begin
              pair_done  = 1'b1;
              left_vld_d = 1'b0;
            end
            ch_d      = (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
        default: state_d = RX_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (pair_done) begin
        if (!valid_q || ready_i) begin
          left_q  <= left_hold_q;
          right_q <= shreg_upd;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign left_o    = left_q;
  assign right_o   = right_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: SCK = clk/8, 32-bit slots, one DUT per WS polarity
// fed the same serial data with mirrored WS.
module tb_i2s_rx;
  logic        clk = 1'b0;
  logic        rst, sck, ws, sd, ready, ws_b;
  logic [23:0] left_a, right_a, left_b, right_b;
  logic        valid_a, valid_b, ovr_a_o, ovr_b_o;
  logic        carry;
  logic [47:0] exp_a[$];
  logic [47:0] exp_b[$];
  logic [47:0] e_a, e_b;
  int          total = 0;
  int          bad = 0;
  int          ovr_a = 0;
  int          ovr_b = 0;
  int          base_a, base_b;

  assign ws_b = ~ws;

  // clock / reset
  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .WS_POL(1'b0), .SYNC_STAGES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .left_o(left_a), .right_o(right_a), .valid_o(valid_a), .ready_i(ready),
    .overrun_o(ovr_a_o)
  );

  i2s_rx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .WS_POL(1'b1), .SYNC_STAGES(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws_b), .sd_i(sd),
    .left_o(left_b), .right_o(right_b), .valid_o(valid_b), .ready_i(ready),
    .overrun_o(ovr_b_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted pair must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && valid_a && ready) begin
      if (exp_a.size() == 0) check("extra_pair_a", 64'(exp_a.size()), 64'd1);
      else begin
        e_a = exp_a.pop_front();
        check("pair_a", {left_a, right_a}, e_a);
      end
    end
    if (!rst && valid_b && ready) begin
      if (exp_b.size() == 0) check("extra_pair_b", 64'(exp_b.size()), 64'd1);
      else begin
        e_b = exp_b.pop_front();
        check("pair_b", {left_b, right_b}, e_b);
      end
    end
    if (!rst && ovr_a_o) ovr_a++;
    if (!rst && ovr_b_o) ovr_b++;
  end

  // driver tasks
  task automatic send_period(input logic w, input logic d, input bit meas, input logic [47:0] mexp);
    @(negedge clk);
    sck = 1'b0; ws = w; sd = d;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    if (meas) begin
      // first posedge after this point samples SCK high; pair lands on the third
      @(negedge clk); check("lat_e0_a", 64'(valid_a), 64'd0);
      @(negedge clk); check("lat_e1_a", 64'(valid_a), 64'd0);
      @(negedge clk); check("lat_e2_a", 64'(valid_a), 64'd1);
      check("lat_data_a", {left_a, right_a}, mexp);
      check("lat_e2_b", 64'(valid_b), 64'd1);
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  // Period 0 carries the previous word's last bit; the slot's own bits follow.
  task automatic send_slot(input logic w, input logic [31:0] data, input int nbits,
                           input bit meas, input logic [47:0] mexp);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) send_period(w, carry, meas, mexp);
      else        send_period(w, data[32-i], 1'b0, 48'h0);
    end
    carry = data[32-nbits];
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, {l, 8'h00}, 32, 1'b0, 48'h0);
    send_slot(1'b1, {r, 8'h00}, 32, 1'b0, 48'h0);
  endtask

  task automatic expect_pair(input logic [23:0] l, input logic [23:0] r);
    exp_a.push_back({l, r});
    exp_b.push_back({l, r});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_a = ovr_a;
    base_b = ovr_b;
  endtask

  task automatic end_test(input string name, input int exp_ovr);
    repeat (4) @(negedge clk);
    check({name, "_q_a"}, 64'(exp_a.size()), 64'd0);
    check({name, "_q_b"}, 64'(exp_b.size()), 64'd0);
    check({name, "_ovr_a"}, 64'(ovr_a - base_a), 64'(exp_ovr));
    check({name, "_ovr_b"}, 64'(ovr_b - base_b), 64'(exp_ovr));
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b1; carry = 1'b0;
    base_a = 0; base_b = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_data", {left_a, right_a}, 64'd0);
    check("rst_ovr", 64'(ovr_a_o), 64'd0);
    check("rst_b", {valid_b, left_b, right_b}, 64'd0);

    // basic pair with latency measurement on the closing WS edge
    do_reset();
    send_slot(1'b1, 32'hDEADBEEF, 32, 1'b0, 48'h0);
    expect_pair(24'h123456, 24'hABCDEF);
    send_frame(24'h123456, 24'hABCDEF);
    send_slot(1'b0, 32'h0, 32, 1'b1, {24'h123456, 24'hABCDEF});
    end_test("basic", 0);

    // backpressure: second pair dropped with a single overrun pulse
    do_reset();
    ready = 1'b0;
    send_slot(1'b1, 32'h0, 32, 1'b0, 48'h0);
    expect_pair(24'h000001, 24'h000002);
    send_frame(24'h000001, 24'h000002);
    send_frame(24'h000003, 24'h000004);
    send_slot(1'b0, 32'h0, 32, 1'b0, 48'h0);
    check("bp_valid_held", 64'(valid_a), 64'd1);
    check("bp_data_held", {left_a, right_a}, {16'h0, 24'h000001, 24'h000002});
    @(posedge clk); #1 ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_valid_drop_a", 64'(valid_a), 64'd0);
    check("bp_valid_drop_b", 64'(valid_b), 64'd0);
    end_test("bp", 1);

    // reset released halfway through a right slot
    base_a = ovr_a; base_b = ovr_b;
    fork
      send_slot(1'b1, {24'h777777, 8'h00}, 32, 1'b0, 48'h0);
      begin
        rst = 1'b1;
        repeat (16 * 8) @(negedge clk);
        rst = 1'b0;
      end
    join
    expect_pair(24'h0F1E2D, 24'h3C4B5A);
    send_frame(24'h0F1E2D, 24'h3C4B5A);
    send_slot(1'b0, 32'h0, 32, 1'b0, 48'h0);
    end_test("midstart", 0);

    // short left word: missing LSBs read zero
    do_reset();
    send_slot(1'b1, 32'h0, 32, 1'b0, 48'h0);
    expect_pair(24'hA5A500, 24'h654321);
    send_slot(1'b0, {16'hA5A5, 16'h0000}, 16, 1'b0, 48'h0);
    send_slot(1'b1, {24'h654321, 8'h00}, 32, 1'b0, 48'h0);
    send_slot(1'b0, 32'h0, 32, 1'b0, 48'h0);
    end_test("short", 0);

    // one-cycle reset during bit 10 of a left word
    do_reset();
    send_slot(1'b1, 32'h0, 32, 1'b0, 48'h0);
    expect_pair(24'h111111, 24'h222222);
    send_frame(24'h111111, 24'h222222);
    fork
      send_slot(1'b0, {24'h333333, 8'h00}, 32, 1'b0, 48'h0);
      begin
        repeat (8 * 10 + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_a", {valid_a, ovr_a_o, left_a, right_a}, 64'd0);
        check("mrst_b", {valid_b, ovr_b_o, left_b, right_b}, 64'd0);
      end
    join
    send_slot(1'b1, {24'h444444, 8'h00}, 32, 1'b0, 48'h0);
    expect_pair(24'h555555, 24'h666666);
    send_frame(24'h555555, 24'h666666);
    send_slot(1'b0, 32'h0, 32, 1'b0, 48'h0);
    end_test("midrst", 0);

    // streaming: 8 back-to-back frames, both polarities
    do_reset();
    send_slot(1'b1, 32'h0, 32, 1'b0, 48'h0);
    for (int i = 0; i < 8; i++) begin
      expect_pair(24'h100000 + 24'(i * 3), 24'hF00000 | 24'(i * 5 + 1));
      send_frame(24'h100000 + 24'(i * 3), 24'hF00000 | 24'(i * 5 + 1));
    end
    send_slot(1'b0, 32'h0, 32, 1'b0, 48'h0);
    end_test("stream", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
